clint_timer_sched: RTL and testbench
====================================

# clint_timer_sched

Hardware timer-event scheduler that multiplexes `NumSlots` independent 64-bit software deadlines onto a single CLINT `mtimecmp` register. It finds the earliest pending deadline by sequential scan and programs it into the CLINT through a 32-bit register-write master, using a glitch-free three-write sequence. When `mtime` reaches a deadline, it retires that slot through an expiry handshake. It sits between a hart-side command source and the CLINT register port for one hart.

## Interface
- `NumSlots`, 4: number of deadline slots (≥2).
- `IdWidth`, `$clog2(NumSlots)`: slot index width.
- `CmpLowAddr`, 32'h0000_4000: CLINT `mtimecmp` low-word address.
- `CmpHighAddr`, 32'h0000_4004: CLINT `mtimecmp` high-word address.

Ports:
- `clk_i` in 1: the only clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `mtime_i` in 64: current CLINT `mtime`.
- `cmd_valid_i` / `cmd_ready_o` in/out 1: command handshake.
- `cmd_op_i` in 1: 0 = ARM, 1 = CANCEL.
- `cmd_id_i` in IdWidth: target slot.
- `cmd_deadline_i` in 64: deadline; used only by ARM.
- `wr_valid_o` / `wr_ready_i` out/in 1: register-write handshake.
- `wr_addr_o` out 32: write address.
- `wr_data_o` out 32: write data.
- `exp_valid_o` / `exp_ready_i` out/in 1: expiry handshake.
- `exp_id_o` out IdWidth: expired slot.
- `busy_o` out 1: the FSM is not in IDLE.

## Operation
- Per-slot state: `valid`, `deadline[63:0]`. Register `prog_q[63:0]` holds the value last written to `mtimecmp`.
- **FSM states:**
  - INIT_WR: reset state. Writes all-ones to `mtimecmp`, then goes to IDLE.
  - IDLE
  - SCAN
  - WR_LO_MAX
  - WR_HI
  - WR_LO
  - FIRE
- **IDLE:**
  - `cmd_ready_o = 1`; it is 0 in every other state.
  - An accepted ARM sets `valid = 1` and `deadline = cmd_deadline_i`, overwriting any existing entry.
  - An accepted CANCEL clears `valid`. Cancelling an invalid slot is a no-op.
  - Either command moves the FSM to SCAN.
  - With no command, `mtime_i >= prog_q` also moves the FSM to SCAN.
- **SCAN:**
  - Visits one slot per cycle, index 0 to `NumSlots`-1.
  - Tracks the minimum valid deadline. On ties, the lower index wins.
  - Tracks the lowest-index slot with `deadline <= mtime_i`, sampled in that slot's cycle.
- **End of scan:**
  - If any slot is expired: go to FIRE with that slot.
  - Else set `target` = the minimum deadline, or all-ones if no slot is valid.
  - If `target == prog_q`: go to IDLE.
  - Otherwise go to WR_LO_MAX.
- **Write sequence:**
  - WR_LO_MAX: `CmpLowAddr` ← FFFF_FFFF.
  - WR_HI: `CmpHighAddr` ← `target[63:32]`.
  - WR_LO: `CmpLowAddr` ← `target[31:0]`.
  - `prog_q` ← `target` on the final write's handshake, then go to IDLE.
  - INIT_WR uses the same three writes with `target` = all-ones.
- **FIRE:**
  - Drives `exp_valid_o = 1` and `exp_id_o` = the slot.
  - On `exp_ready_i`: clear the slot's `valid`, then go to SCAN.
  - Multiple expired slots retire one per FIRE/SCAN loop, in index order.
- Compares are unsigned 64-bit. `mtime` wrap-around is not handled.

## Timing
- **Reset values:**
  - `cmd_ready_o` = 0, `exp_valid_o` = 0, `wr_valid_o` = 0, `busy_o` = 1.
  - `wr_addr_o` = 0, `wr_data_o` = 0, `exp_id_o` = 0.
  - All slots invalid, `prog_q` = all-ones, state = INIT_WR.
- In INIT_WR, `wr_valid_o` rises the first cycle after reset deasserts. Reset asserted mid-sequence aborts it and restarts at INIT_WR.
- A command accepted at cycle t updates the slot at t+1. SCAN occupies t+1 .. t+`NumSlots`.
- Every write holds `wr_valid_o`, `wr_addr_o` and `wr_data_o` stable until `wr_ready_i`; there is at most one write per cycle. With `wr_ready_i` tied high, the sequence takes 3 cycles.
- `exp_valid_o` and `exp_id_o` are stable until handshake. `exp_valid_o` never drops without `exp_ready_i`.
- All outputs are registered, except `cmd_ready_o` and `busy_o`, which decode the state register directly.

## Structure
- **Package `clint_sched_pkg`:**
  - `sched_state_e` enum.
  - `slot_t` struct {`valid`, `deadline`}.
  - `OpArm` / `OpCancel` constants.
  - Default CLINT `mtimecmp` offsets.
- **Sub-module `clint_cmp_writer`:**
  - Three-write `mtimecmp` sequencer.
  - Inputs: `start`, `target`. Output: `done`. Also owns the `wr_*` interface.
  - Used by both INIT_WR and the WR_* states.

## Test plan
- **Reset:**
  - Stimulus: release reset with `wr_ready_i` = 1.
  - Required: writes (4000 ← FFFF_FFFF), (4004 ← FFFF_FFFF), (4000 ← FFFF_FFFF), then IDLE with `cmd_ready_o` = 1.
  - Required: no further writes while no command is issued.
- **Earliest-deadline programming:**
  - Stimulus: with `mtime` = 0, ARM slot 2 at 0x1_0000_0200, then ARM slot 0 at 0x300.
  - Required: first write group is FFFF_FFFF / 0000_0001 / 0000_0200.
  - Required: second group is FFFF_FFFF / 0 / 0000_0300.
- **Expiry and reprogram:**
  - Stimulus: with the state above, ramp `mtime` to 0x300.
  - Required: `exp_id_o` = 0 appears; after handshake, `mtimecmp` is reprogrammed to 0x1_0000_0200.
- **Tie and past deadline:**
  - Stimulus: ARM slots 1 and 3 both at 0x50 while `mtime` = 0x80.
  - Required: expire slot 1, then slot 3, with no write for that target; then writes of all-ones.
- **Back-pressure:**
  - Stimulus: hold `wr_ready_i` = 0 for 5 cycles, then hold `exp_ready_i` = 0 for 5 cycles.
  - Required: outputs stay stable through both stalls; `cmd_ready_o` stays 0 throughout.
- **Cancel:**
  - Stimulus: CANCEL the only armed slot.
  - Required: `mtimecmp` is rewritten to all-ones and `exp_valid_o` never rises.

Source files
------------

// File: rtl/clint_sched_pkg.sv
// Shared types and constants for the CLINT timer-event scheduler.
package clint_sched_pkg;

   typedef enum logic [2:0] {
      ST_INIT_WR,
      ST_IDLE,
      ST_SCAN,
      ST_WR_LO_MAX,
      ST_WR_HI,
      ST_WR_LO,
      ST_FIRE
   } sched_state_e;

   typedef enum logic [1:0] {
      WP_IDLE,
      WP_LO_MAX,
      WP_HI,
      WP_LO
   } wr_phase_e;

   typedef struct packed {
      logic        valid;
      logic [63:0] deadline;
   } slot_t;

   localparam logic OpArm    = 1'b0;
   localparam logic OpCancel = 1'b1;

   localparam logic [31:0] DefCmpLowAddr  = 32'h0000_4000;
   localparam logic [31:0] DefCmpHighAddr = 32'h0000_4004;

   localparam logic [63:0] AllOnes = '1;

endpackage

// File: rtl/clint_cmp_writer.sv
// Three-write mtimecmp sequencer: low <- all-ones, high <- target[63:32], low <- target[31:0].
module clint_cmp_writer
   import clint_sched_pkg::*;
#(
   parameter logic [31:0] CmpLowAddr  = DefCmpLowAddr,
   parameter logic [31:0] CmpHighAddr = DefCmpHighAddr
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [63:0] target_i,
   output logic        done_o,
   output logic        idle_o,
   output logic        wr_valid_o,
   input  logic        wr_ready_i,
   output logic [31:0] wr_addr_o,
   output logic [31:0] wr_data_o
);

   wr_phase_e   phase_q, phase_d;
   logic        valid_q, valid_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [63:0] tgt_q, tgt_d;

   always_comb begin
      phase_d = phase_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      tgt_d   = tgt_q;
      done_o  = 1'b0;
      // Parking the low word at all-ones first keeps the compare from firing
      // on a half-updated value while the high word changes.
      unique case (phase_q)
         WP_IDLE: begin
            if (start_i) begin
               tgt_d   = target_i;
               valid_d = 1'b1;
               addr_d  = CmpLowAddr;
               data_d  = 32'hFFFF_FFFF;
               phase_d = WP_LO_MAX;
            end
         end
         WP_LO_MAX: begin
            if (wr_ready_i) begin
               addr_d  = CmpHighAddr;
               data_d  = tgt_q[63:32];
               phase_d = WP_HI;
            end
         end
         WP_HI: begin
            if (wr_ready_i) begin
               addr_d  = CmpLowAddr;
               data_d  = tgt_q[31:0];
               phase_d = WP_LO;
            end
         end
         WP_LO: begin
            if (wr_ready_i) begin
               valid_d = 1'b0;
               done_o  = 1'b1;
               phase_d = WP_IDLE;
            end
         end
         default: phase_d = WP_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      tgt_q <= tgt_d;
      if (rst_i) begin
         phase_q <= WP_IDLE;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         phase_q <= phase_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign idle_o     = (phase_q == WP_IDLE);
   assign wr_valid_o = valid_q;
   assign wr_addr_o  = addr_q;
   assign wr_data_o  = data_q;

endmodule

// File: rtl/clint_timer_sched.sv
// Multiplexes NumSlots software deadlines onto one CLINT mtimecmp: sequential
// earliest-deadline scan, glitch-free reprogramming and one-at-a-time expiry.
module clint_timer_sched
   import clint_sched_pkg::*;
#(
   parameter int unsigned NumSlots    = 4,
   parameter int unsigned IdWidth     = $clog2(NumSlots),
   parameter logic [31:0] CmpLowAddr  = DefCmpLowAddr,
   parameter logic [31:0] CmpHighAddr = DefCmpHighAddr
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [63:0]        mtime_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic               cmd_op_i,
   input  logic [IdWidth-1:0] cmd_id_i,
   input  logic [63:0]        cmd_deadline_i,
   output logic               wr_valid_o,
   input  logic               wr_ready_i,
   output logic [31:0]        wr_addr_o,
   output logic [31:0]        wr_data_o,
   output logic               exp_valid_o,
   input  logic               exp_ready_i,
   output logic [IdWidth-1:0] exp_id_o,
   output logic               busy_o
);

   sched_state_e       state_q, state_d;
   slot_t              slots_q [NumSlots];
   slot_t              slots_d [NumSlots];
   logic [63:0]        prog_q, prog_d;
   logic [63:0]        tgt_q, tgt_d;
   logic [IdWidth-1:0] scan_idx_q, scan_idx_d;
   logic               min_valid_q, min_valid_d;
   logic [63:0]        min_dl_q, min_dl_d;
   logic               exp_found_q, exp_found_d;
   logic [IdWidth-1:0] exp_slot_q, exp_slot_d;
   logic               exp_valid_q, exp_valid_d;
   logic [IdWidth-1:0] exp_id_q, exp_id_d;

   slot_t              cur_slot;
   logic [63:0]        scan_tgt;
   logic               enter_scan;
   logic               wr_start;
   logic [63:0]        wr_target;
   logic               wr_done;
   logic               wr_idle;

   assign cur_slot = slots_q[scan_idx_q];

   always_comb begin
      state_d     = state_q;
      slots_d     = slots_q;
      prog_d      = prog_q;
      tgt_d       = tgt_q;
      scan_idx_d  = scan_idx_q;
      min_valid_d = min_valid_q;
      min_dl_d    = min_dl_q;
      exp_found_d = exp_found_q;
      exp_slot_d  = exp_slot_q;
      exp_valid_d = exp_valid_q;
      exp_id_d    = exp_id_q;
      scan_tgt    = AllOnes;
      enter_scan  = 1'b0;
      wr_start    = 1'b0;
      wr_target   = AllOnes;

      unique case (state_q)
         ST_INIT_WR: begin
            wr_start = wr_idle;
            if (wr_start) tgt_d = AllOnes;
            if (wr_done) begin
               prog_d  = tgt_q;
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (cmd_valid_i) begin
               if (cmd_op_i == OpArm) begin
                  slots_d[cmd_id_i].valid    = 1'b1;
                  slots_d[cmd_id_i].deadline = cmd_deadline_i;
               end else begin
                  slots_d[cmd_id_i].valid = 1'b0;
               end
               enter_scan = 1'b1;
            end else if (mtime_i >= prog_q) begin
               enter_scan = 1'b1;
            end
         end
         ST_SCAN: begin
            // Strict less-than keeps the lower index on equal deadlines.
            if (cur_slot.valid && (!min_valid_q || cur_slot.deadline < min_dl_q)) begin
               min_valid_d = 1'b1;
               min_dl_d    = cur_slot.deadline;
            end
            if (!exp_found_q && cur_slot.valid && cur_slot.deadline <= mtime_i) begin
               exp_found_d = 1'b1;
               exp_slot_d  = scan_idx_q;
            end
            if (scan_idx_q == IdWidth'(NumSlots - 1)) begin
               scan_tgt = min_valid_d ? min_dl_d : AllOnes;
               if (exp_found_d) begin
                  exp_valid_d = 1'b1;
                  exp_id_d    = exp_slot_d;
                  state_d     = ST_FIRE;
               end else if (scan_tgt == prog_q) begin
                  state_d = ST_IDLE;
               end else begin
                  wr_start  = 1'b1;
                  wr_target = scan_tgt;
                  tgt_d     = scan_tgt;
                  state_d   = ST_WR_LO_MAX;
               end
            end else begin
               scan_idx_d = scan_idx_q + 1'b1;
            end
         end
         ST_WR_LO_MAX: if (wr_valid_o && wr_ready_i) state_d = ST_WR_HI;
         ST_WR_HI:     if (wr_valid_o && wr_ready_i) state_d = ST_WR_LO;
         ST_WR_LO: begin
            if (wr_done) begin
               prog_d  = tgt_q;
               state_d = ST_IDLE;
            end
         end
         ST_FIRE: begin
            if (exp_ready_i) begin
               slots_d[exp_id_q].valid = 1'b0;
               exp_valid_d = 1'b0;
               enter_scan  = 1'b1;
            end
         end
         default: state_d = ST_INIT_WR;
      endcase

      if (enter_scan) begin
         state_d     = ST_SCAN;
         scan_idx_d  = '0;
         min_valid_d = 1'b0;
         exp_found_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      tgt_q      <= tgt_d;
      min_dl_q   <= min_dl_d;
      exp_slot_q <= exp_slot_d;
      for (int i = 0; i < NumSlots; i++) begin
         slots_q[i].deadline <= slots_d[i].deadline;
         slots_q[i].valid    <= rst_i ? 1'b0 : slots_d[i].valid;
      end
      if (rst_i) begin
         state_q     <= ST_INIT_WR;
         prog_q      <= AllOnes;
         scan_idx_q  <= '0;
         min_valid_q <= 1'b0;
         exp_found_q <= 1'b0;
         exp_valid_q <= 1'b0;
         exp_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         prog_q      <= prog_d;
         scan_idx_q  <= scan_idx_d;
         min_valid_q <= min_valid_d;
         exp_found_q <= exp_found_d;
         exp_valid_q <= exp_valid_d;
         exp_id_q    <= exp_id_d;
      end
   end

   clint_cmp_writer #(
      .CmpLowAddr (CmpLowAddr),
      .CmpHighAddr(CmpHighAddr)
   ) u_writer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (wr_start),
      .target_i  (wr_target),
      .done_o    (wr_done),
      .idle_o    (wr_idle),
      .wr_valid_o(wr_valid_o),
      .wr_ready_i(wr_ready_i),
      .wr_addr_o (wr_addr_o),
      .wr_data_o (wr_data_o)
   );

   assign cmd_ready_o = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign exp_valid_o = exp_valid_q;
   assign exp_id_o    = exp_id_q;

endmodule

// File: tb/tb_clint_timer_sched.sv
// Directed bench for clint_timer_sched: command vector table plus hand-written
// expiry, tie, stall, cancel and mid-sequence reset sequences.
module tb_clint_timer_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] mtime;
   logic        cmd_valid;
   logic        cmd_ready_o;
   logic        cmd_op;
   logic [1:0]  cmd_id;
   logic [63:0] cmd_deadline;
   logic        wr_valid_o;
   logic        wr_ready;
   logic [31:0] wr_addr_o;
   logic [31:0] wr_data_o;
   logic        exp_valid_o;
   logic        exp_ready;
   logic [1:0]  exp_id_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clint_timer_sched dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .mtime_i       (mtime),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_op_i      (cmd_op),
      .cmd_id_i      (cmd_id),
      .cmd_deadline_i(cmd_deadline),
      .wr_valid_o    (wr_valid_o),
      .wr_ready_i    (wr_ready),
      .wr_addr_o     (wr_addr_o),
      .wr_data_o     (wr_data_o),
      .exp_valid_o   (exp_valid_o),
      .exp_ready_i   (exp_ready),
      .exp_id_o      (exp_id_o),
      .busy_o        (busy_o)
   );

   typedef struct {
      logic        op;
      logic [1:0]  id;
      logic [63:0] dl;
      logic        wr;
      logic [63:0] tgt;
   } vec_t;

   vec_t vecs [8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic send_cmd(input logic op, input logic [1:0] id, input logic [63:0] dl);
      int n = 0;
      while (!cmd_ready_o && n < 100) begin
         step();
         n++;
      end
      chk("cmd_ready_wait", cmd_ready_o, 1);
      cmd_valid    = 1'b1;
      cmd_op       = op;
      cmd_id       = id;
      cmd_deadline = dl;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic expect_write(input string nm, input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      while (!wr_valid_o && n < 60) begin
         step();
         n++;
      end
      chk({nm, "_valid"}, wr_valid_o, 1);
      if (wr_valid_o) begin
         chk({nm, "_addr"}, wr_addr_o, a);
         chk({nm, "_data"}, wr_data_o, d);
         step();
      end
   endtask

   task automatic expect_group(input string nm, input logic [63:0] tgt);
      expect_write({nm, "_lomax"}, 32'h4000, 32'hFFFF_FFFF);
      expect_write({nm, "_hi"},    32'h4004, tgt[63:32]);
      expect_write({nm, "_lo"},    32'h4000, tgt[31:0]);
   endtask

   task automatic expect_exp(input string nm, input logic [1:0] id);
      int n = 0;
      while (!exp_valid_o && n < 60) begin
         step();
         n++;
      end
      chk({nm, "_valid"}, exp_valid_o, 1);
      if (exp_valid_o) begin
         chk({nm, "_id"}, exp_id_o, id);
         step();
      end
   endtask

   task automatic quiet(input string nm, input int cycles);
      int wr_seen = 0;
      int exp_seen = 0;
      for (int i = 0; i < cycles; i++) begin
         if (wr_valid_o) wr_seen++;
         if (exp_valid_o) exp_seen++;
         step();
      end
      chk({nm, "_no_wr"}, wr_seen, 0);
      chk({nm, "_no_exp"}, exp_seen, 0);
      chk({nm, "_ready"}, cmd_ready_o, 1);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_cmd_ready"}, cmd_ready_o, 0);
      chk({nm, "_busy"},      busy_o, 1);
      chk({nm, "_wr_valid"},  wr_valid_o, 0);
      chk({nm, "_wr_addr"},   wr_addr_o, 0);
      chk({nm, "_wr_data"},   wr_data_o, 0);
      chk({nm, "_exp_valid"}, exp_valid_o, 0);
      chk({nm, "_exp_id"},    exp_id_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int n;
      logic [31:0] a0, d0;

      vecs[0] = '{1'b0, 2'd2, 64'h1_0000_0200, 1'b1, 64'h1_0000_0200};
      vecs[1] = '{1'b0, 2'd0, 64'h300,         1'b1, 64'h300};
      vecs[2] = '{1'b0, 2'd1, 64'h280,         1'b1, 64'h280};
      vecs[3] = '{1'b1, 2'd1, 64'h0,           1'b1, 64'h300};
      vecs[4] = '{1'b0, 2'd3, 64'h300,         1'b0, 64'h300};
      vecs[5] = '{1'b1, 2'd3, 64'h0,           1'b0, 64'h300};
      vecs[6] = '{1'b1, 2'd1, 64'h0,           1'b0, 64'h300};
      vecs[7] = '{1'b0, 2'd0, 64'h300,         1'b0, 64'h300};

      rst          = 1'b1;
      mtime        = 64'h0;
      cmd_valid    = 1'b0;
      cmd_op       = 1'b0;
      cmd_id       = 2'd0;
      cmd_deadline = 64'h0;
      wr_ready     = 1'b1;
      exp_ready    = 1'b1;

      // Reset and initial all-ones programming.
      repeat (3) step();
      chk_reset_outputs("rst");
      rst = 1'b0;
      step();
      chk("init_rise", wr_valid_o, 1);
      expect_group("init", 64'hFFFF_FFFF_FFFF_FFFF);
      chk("init_idle_ready", cmd_ready_o, 1);
      chk("init_idle_busy", busy_o, 0);
      quiet("init_quiet", 20);

      // Command table at mtime = 0.
      for (int i = 0; i < 8; i++) begin
         send_cmd(vecs[i].op, vecs[i].id, vecs[i].dl);
         if (vecs[i].wr) begin
            expect_group($sformatf("vec%0d", i), vecs[i].tgt);
            chk($sformatf("vec%0d_ready", i), cmd_ready_o, 1);
         end else begin
            quiet($sformatf("vec%0d", i), 12);
         end
      end

      // Ramp mtime up to slot 0's deadline.
      bad = 0;
      for (int m = 'h2F0; m < 'h300; m++) begin
         mtime = 64'(m);
         step();
         if (exp_valid_o || wr_valid_o) bad++;
      end
      chk("ramp_early", bad, 0);
      mtime = 64'h300;
      expect_exp("exp0", 2'd0);
      expect_group("reprog", 64'h1_0000_0200);

      // Deadlines already in the past: each fires without a write.
      mtime = 64'h80;
      send_cmd(1'b0, 2'd1, 64'h50);
      expect_exp("past1", 2'd1);
      quiet("past1", 12);
      send_cmd(1'b0, 2'd3, 64'h50);
      expect_exp("past3", 2'd3);
      quiet("past3", 12);

      // Cancel the only armed slot.
      send_cmd(1'b1, 2'd2, 64'h0);
      expect_group("cancel", 64'hFFFF_FFFF_FFFF_FFFF);
      quiet("cancel", 12);

      // Tie with write back-pressure, then expiry back-pressure.
      mtime    = 64'h10;
      wr_ready = 1'b0;
      send_cmd(1'b0, 2'd1, 64'h50);
      n = 0;
      while (!wr_valid_o && n < 60) begin
         step();
         n++;
      end
      a0 = wr_addr_o;
      d0 = wr_data_o;
      chk("wrstall_addr", a0, 32'h4000);
      chk("wrstall_data", d0, 32'hFFFF_FFFF);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (!wr_valid_o || wr_addr_o != a0 || wr_data_o != d0 || cmd_ready_o) bad++;
      end
      chk("wrstall_stable", bad, 0);
      wr_ready = 1'b1;
      expect_group("tie_arm", 64'h50);
      send_cmd(1'b0, 2'd3, 64'h50);
      quiet("tie_same", 12);
      exp_ready = 1'b0;
      mtime     = 64'h80;
      n = 0;
      while (!exp_valid_o && n < 60) begin
         step();
         n++;
      end
      chk("expstall_valid", exp_valid_o, 1);
      chk("expstall_id", exp_id_o, 2'd1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (!exp_valid_o || exp_id_o != 2'd1 || cmd_ready_o || wr_valid_o) bad++;
      end
      chk("expstall_stable", bad, 0);
      exp_ready = 1'b1;
      step();
      expect_exp("tie_second", 2'd3);
      expect_group("tie_clear", 64'hFFFF_FFFF_FFFF_FFFF);
      chk("tie_ready", cmd_ready_o, 1);

      // Reset in the middle of a write sequence restarts at INIT_WR.
      send_cmd(1'b0, 2'd0, 64'h1000);
      n = 0;
      while (!wr_valid_o && n < 60) begin
         step();
         n++;
      end
      chk("midrst_started", wr_valid_o, 1);
      rst = 1'b1;
      step();
      chk_reset_outputs("midrst");
      rst = 1'b0;
      step();
      chk("midrst_rise", wr_valid_o, 1);
      expect_group("midrst_init", 64'hFFFF_FFFF_FFFF_FFFF);
      quiet("midrst_quiet", 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
